// File: rtl/core_avalon_bridge.sv
// Core-bus to Avalon-MM bridge. It allows one transaction in flight at a time, aborts any
// transaction that runs past the response timeout, and synchronizes the platform interrupt.
module core_avalon_bridge #(
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter logic [31:0] FAULT_DATA     = 32'hDEADBEEF
) (
    input  logic        clk,
    input  logic        rst_n,
    // core side
    input  logic [29:0] addr,
    input  logic        start,
    input  logic        write,
    input  logic [31:0] data_wr,
    input  logic [3:0]  data_be,
    output logic [31:0] data_rd,
    output logic        ready,
    output logic        irq,
    output logic        bus_fault,
    output logic        protocol_err,
    // Avalon-MM master side
    output logic [31:0] avl_address,
    output logic        avl_read,
    output logic        avl_write,
    output logic [31:0] avl_writedata,
    output logic [3:0]  avl_byteenable,
    input  logic [31:0] avl_readdata,
    input  logic        avl_readdatavalid,
    input  logic        avl_waitrequest,
    input  logic        avl_irq
);

    typedef enum logic [1:0] {StIdle, StReq, StWaitData} state_t;

    // The timer only has to reach TIMEOUT_CYCLES-1 before it triggers an abort.
    localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TIMER_LAST = TW'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

    state_t         state_q, state_d;
    logic [TW-1:0]  timer_q, timer_d;
    logic           is_write_q, is_write_d;
    logic [31:0]    data_rd_q, data_rd_d;
    logic           ready_q, ready_d;
    logic           bus_fault_q, bus_fault_d;
    logic           protocol_err_q, protocol_err_d;
    logic [31:0]    avl_address_q, avl_address_d;
    logic           avl_read_q, avl_read_d;
    logic           avl_write_q, avl_write_d;
    logic [31:0]    avl_writedata_q, avl_writedata_d;
    logic [3:0]     avl_byteenable_q, avl_byteenable_d;
    logic [1:0]     irq_sync_q;
    logic           timeout_hit;

    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (timer_q == TIMER_LAST);

    // Next-state logic: transaction sequencing, timeout abort and the sticky protocol error
    always_comb begin
        state_d          = state_q;
        timer_d          = timer_q;
        is_write_d       = is_write_q;
        data_rd_d        = data_rd_q;
        ready_d          = 1'b0;
        bus_fault_d      = 1'b0;
        protocol_err_d   = protocol_err_q | (start && (state_q != StIdle));
        avl_address_d    = avl_address_q;
        avl_read_d       = avl_read_q;
        avl_write_d      = avl_write_q;
        avl_writedata_d  = avl_writedata_q;
        avl_byteenable_d = avl_byteenable_q;

        if (state_q != StIdle && timer_q != '1) begin
            timer_d = timer_q + 1'b1;
        end

        unique case (state_q)
            StIdle: begin
                // A late readdatavalid after an abort lands here and is ignored.
                if (start) begin
                    avl_address_d    = {addr, 2'b00};
                    avl_writedata_d  = data_wr;
                    avl_byteenable_d = data_be;
                    avl_read_d       = !write;
                    avl_write_d      = write;
                    is_write_d       = write;
                    timer_d          = '0;
                    state_d          = StReq;
                end
            end
            StReq: begin
                if (!avl_waitrequest) begin
                    avl_read_d  = 1'b0;
                    avl_write_d = 1'b0;
                    if (is_write_q) begin
                        ready_d = 1'b1;
                        state_d = StIdle;
                    end else if (avl_readdatavalid) begin
                        data_rd_d = avl_readdata;
                        ready_d   = 1'b1;
                        state_d   = StIdle;
                    end else if (timeout_hit) begin
                        ready_d     = 1'b1;
                        bus_fault_d = 1'b1;
                        data_rd_d   = FAULT_DATA;
                        state_d     = StIdle;
                    end else begin
                        state_d = StWaitData;
                    end
                end else if (timeout_hit) begin
                    avl_read_d  = 1'b0;
                    avl_write_d = 1'b0;
                    ready_d     = 1'b1;
                    bus_fault_d = 1'b1;
                    if (!is_write_q) begin
                        data_rd_d = FAULT_DATA;
                    end
                    state_d = StIdle;
                end
            end
            StWaitData: begin
                if (avl_readdatavalid) begin
                    data_rd_d = avl_readdata;
                    ready_d   = 1'b1;
                    state_d   = StIdle;
                end else if (timeout_hit) begin
                    ready_d     = 1'b1;
                    bus_fault_d = 1'b1;
                    data_rd_d   = FAULT_DATA;
                    state_d     = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and registered-output update
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= StIdle;
            timer_q          <= '0;
            is_write_q       <= 1'b0;
            data_rd_q        <= '0;
            ready_q          <= 1'b0;
            bus_fault_q      <= 1'b0;
            protocol_err_q   <= 1'b0;
            avl_address_q    <= '0;
            avl_read_q       <= 1'b0;
            avl_write_q      <= 1'b0;
            avl_writedata_q  <= '0;
            avl_byteenable_q <= '0;
        end else begin
            state_q          <= state_d;
            timer_q          <= timer_d;
            is_write_q       <= is_write_d;
            data_rd_q        <= data_rd_d;
            ready_q          <= ready_d;
            bus_fault_q      <= bus_fault_d;
            protocol_err_q   <= protocol_err_d;
            avl_address_q    <= avl_address_d;
            avl_read_q       <= avl_read_d;
            avl_write_q      <= avl_write_d;
            avl_writedata_q  <= avl_writedata_d;
            avl_byteenable_q <= avl_byteenable_d;
        end
    end

    // Two-flop synchronizer for the asynchronous platform interrupt
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq_sync_q <= 2'b00;
        end else begin
            irq_sync_q <= {irq_sync_q[0], avl_irq};
        end
    end

    assign data_rd        = data_rd_q;
    assign ready          = ready_q;
    assign bus_fault      = bus_fault_q;
    assign protocol_err   = protocol_err_q;
    assign irq            = irq_sync_q[1];
    assign avl_address    = avl_address_q;
    assign avl_read       = avl_read_q;
    assign avl_write      = avl_write_q;
    assign avl_writedata  = avl_writedata_q;
    assign avl_byteenable = avl_byteenable_q;

endmodule

// File: tb/tb_core_avalon_bridge.sv
// Directed testbench for core_avalon_bridge with an 8-cycle timeout.
module tb_core_avalon_bridge;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [29:0] addr = '0;
    logic        start = 1'b0;
    logic        write = 1'b0;
    logic [31:0] data_wr = '0;
    logic [3:0]  data_be = '0;
    logic [31:0] data_rd;
    logic        ready;
    logic        irq;
    logic        bus_fault;
    logic        protocol_err;
    logic [31:0] avl_address;
    logic        avl_read;
    logic        avl_write;
    logic [31:0] avl_writedata;
    logic [3:0]  avl_byteenable;
    logic [31:0] avl_readdata = '0;
    logic        avl_readdatavalid = 1'b0;
    logic        avl_waitrequest = 1'b0;
    logic        avl_irq = 1'b0;

    int checks = 0;
    int failures = 0;

    core_avalon_bridge #(
        .TIMEOUT_CYCLES(8),
        .FAULT_DATA    (32'hDEADBEEF)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .addr             (addr),
        .start            (start),
        .write            (write),
        .data_wr          (data_wr),
        .data_be          (data_be),
        .data_rd          (data_rd),
        .ready            (ready),
        .irq              (irq),
        .bus_fault        (bus_fault),
        .protocol_err     (protocol_err),
        .avl_address      (avl_address),
        .avl_read         (avl_read),
        .avl_write        (avl_write),
        .avl_writedata    (avl_writedata),
        .avl_byteenable   (avl_byteenable),
        .avl_readdata     (avl_readdata),
        .avl_readdatavalid(avl_readdatavalid),
        .avl_waitrequest  (avl_waitrequest),
        .avl_irq          (avl_irq)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive a one-cycle start in the current cycle and move into the next one.
    task automatic issue(input logic wr, input logic [29:0] a, input logic [31:0] d,
                         input logic [3:0] be);
        start   = 1'b1;
        write   = wr;
        addr    = a;
        data_wr = d;
        data_be = be;
        step();
        start = 1'b0;
    endtask

    initial begin
        // Reset state
        #12;
        check_eq("rst_avl_read", avl_read, 0);
        check_eq("rst_avl_write", avl_write, 0);
        check_eq("rst_avl_address", avl_address, 0);
        check_eq("rst_data_rd", data_rd, 0);
        check_eq("rst_ready", ready, 0);
        check_eq("rst_protocol_err", protocol_err, 0);
        rst_n = 1'b1;
        step();

        // Zero-wait write
        issue(1'b1, 30'h10, 32'h12345678, 4'hF);
        check_eq("wr_avl_address", avl_address, 32'h40);
        check_eq("wr_avl_write", avl_write, 1);
        check_eq("wr_avl_writedata", avl_writedata, 32'h12345678);
        check_eq("wr_avl_byteenable", avl_byteenable, 32'hF);
        check_eq("wr_ready_t1", ready, 0);
        step();
        check_eq("wr_avl_write_drop", avl_write, 0);
        check_eq("wr_ready_t2", ready, 1);
        step();
        check_eq("wr_ready_t3", ready, 0);

        // Read with three stall cycles then data two cycles after acceptance
        avl_waitrequest = 1'b1;
        issue(1'b0, 30'h14, 32'h0, 4'hF);
        check_eq("rd_avl_read_t1", avl_read, 1);
        check_eq("rd_avl_address", avl_address, 32'h50);
        step();
        check_eq("rd_avl_read_t2", avl_read, 1);
        step();
        check_eq("rd_avl_read_t3", avl_read, 1);
        step();
        avl_waitrequest = 1'b0;
        step();
        check_eq("rd_avl_read_drop", avl_read, 0);
        check_eq("rd_ready_early", ready, 0);
        step();
        avl_readdatavalid = 1'b1;
        avl_readdata      = 32'hCAFEF00D;
        step();
        avl_readdatavalid = 1'b0;
        check_eq("rd_ready", ready, 1);
        check_eq("rd_data", data_rd, 32'hCAFEF00D);
        step();
        check_eq("rd_ready_single", ready, 0);
        check_eq("rd_data_held", data_rd, 32'hCAFEF00D);

        // Read to a silent slave times out on the ninth cycle after start
        issue(1'b0, 30'h20, 32'h0, 4'hF);
        for (int k = 1; k <= 7; k++) begin
            check_eq("to_no_ready", ready, 0);
            step();
        end
        check_eq("to_no_ready_t8", ready, 0);
        step();
        check_eq("to_ready", ready, 1);
        check_eq("to_bus_fault", bus_fault, 1);
        check_eq("to_data", data_rd, 32'hDEADBEEF);
        avl_readdatavalid = 1'b1;
        avl_readdata      = 32'h00012345;
        step();
        avl_readdatavalid = 1'b0;
        check_eq("to_bus_fault_drop", bus_fault, 0);
        step();
        check_eq("late_rdv_ready", ready, 0);
        check_eq("late_rdv_data", data_rd, 32'hDEADBEEF);

        // start during WAIT_DATA is flagged and ignored
        issue(1'b0, 30'h30, 32'h0, 4'hF);
        step();
        issue(1'b1, 30'h31, 32'h55555555, 4'h3);
        check_eq("pe_flag", protocol_err, 1);
        check_eq("pe_no_write", avl_write, 0);
        check_eq("pe_addr_kept", avl_address, 32'hC0);
        avl_readdatavalid = 1'b1;
        avl_readdata      = 32'hA5A5A5A5;
        step();
        avl_readdatavalid = 1'b0;
        check_eq("pe_ready", ready, 1);
        check_eq("pe_data", data_rd, 32'hA5A5A5A5);
        step();
        step();
        check_eq("pe_sticky", protocol_err, 1);

        // Back-to-back: read issued in the write's ready cycle, data taken on acceptance
        issue(1'b1, 30'h1, 32'h11112222, 4'hF);
        step();
        check_eq("b2b_ready", ready, 1);
        issue(1'b0, 30'h3, 32'h0, 4'hF);
        check_eq("b2b_avl_read", avl_read, 1);
        check_eq("b2b_avl_address", avl_address, 32'hC);
        avl_readdatavalid = 1'b1;
        avl_readdata      = 32'h0BADF00D;
        step();
        avl_readdatavalid = 1'b0;
        check_eq("b2b_ready2", ready, 1);
        check_eq("b2b_data", data_rd, 32'h0BADF00D);

        // Interrupt synchronizer latency
        avl_irq = 1'b1;
        step();
        avl_irq = 1'b0;
        check_eq("irq_c1", irq, 0);
        step();
        check_eq("irq_c2", irq, 1);
        step();
        check_eq("irq_c3", irq, 0);

        // Asynchronous reset mid-read
        avl_waitrequest = 1'b1;
        issue(1'b0, 30'h40, 32'h0, 4'hF);
        check_eq("ar_avl_read_pre", avl_read, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("ar_avl_read_async", avl_read, 0);
        step();
        check_eq("ar_ready_in_reset", ready, 0);
        rst_n           = 1'b1;
        avl_waitrequest = 1'b0;
        step();
        check_eq("ar_ready_after", ready, 0);
        check_eq("ar_pe_cleared", protocol_err, 0);
        issue(1'b1, 30'h2, 32'h77778888, 4'h1);
        check_eq("ar_idle_write", avl_write, 1);
        step();
        check_eq("ar_idle_ready", ready, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
